// File: rtl/spi_frame_pkg.sv
// Shared types and helpers for the SPI frame slave receiver.
// Optional MISO return path is enabled by defining SPI_FRAME_TX_EN.
package spi_frame_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        CHECK
    } spi_state_e;

    typedef enum logic {
        EDGE_RISE,
        EDGE_FALL
    } spi_edge_e;

    localparam int SYNC_STAGES = 2;

    function automatic int frame_bits(input int data_w);
        return 8 * ((data_w + 7) / 8);
    endfunction

    // Sample on the rising SCLK edge when CPOL==CPHA, otherwise falling.
    function automatic spi_edge_e sample_edge(input bit cpol, input bit cpha);
        return (cpol == cpha) ? EDGE_RISE : EDGE_FALL;
    endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Two-flop synchroniser plus history flop for edge detection on one pin.
module spi_pin_sync
    import spi_frame_pkg::*;
(
    input  logic clk_i,
    input  logic rst_ni,
    input  logic pin_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level_o = sync_q[SYNC_STAGES-1];
    assign rise_o  = level_o & ~hist_q;
    assign fall_o  = ~level_o & hist_q;

endmodule

// File: rtl/spi_frame_slave.sv
// SPI slave receiver: one MSB-first frame per SS window into a DATA_W word.
// Define SPI_FRAME_TX_EN to build the tx shift register and MISO path.
module spi_frame_slave
    import spi_frame_pkg::*;
#(
    parameter int DATA_W = 14,
    parameter bit CPOL   = 1'b0,
    parameter bit CPHA   = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sclk,
    input  logic              mosi,
    input  logic              ss,
    output logic              miso,
    input  logic [DATA_W-1:0] i_tx_data,
    output logic [DATA_W-1:0] o_data,
    output logic              o_data_valid,
    output logic              o_frame_err
);

    localparam int FB = frame_bits(DATA_W);
    localparam int CW = $clog2(FB + 2);
    localparam logic [CW-1:0] CNT_FULL = CW'(FB);
    localparam logic [CW-1:0] CNT_MAX  = CW'(FB + 1);
    localparam spi_edge_e SEDGE = sample_edge(CPOL, CPHA);
    localparam logic [FB-1:0] PAD_MASK =
        ~FB'((64'd1 << DATA_W) - 64'd1);

    logic sclk_rise, sclk_fall;
    logic ss_lvl, ss_rise, ss_fall;
    logic mosi_lvl;
    logic unused_sclk_lvl, unused_mosi_rise, unused_mosi_fall;

    spi_pin_sync u_sclk (
        .clk_i  (clk),
        .rst_ni (reset),
        .pin_i  (sclk),
        .level_o(unused_sclk_lvl),
        .rise_o (sclk_rise),
        .fall_o (sclk_fall)
    );

    spi_pin_sync u_ss (
        .clk_i  (clk),
        .rst_ni (reset),
        .pin_i  (ss),
        .level_o(ss_lvl),
        .rise_o (ss_rise),
        .fall_o (ss_fall)
    );

    spi_pin_sync u_mosi (
        .clk_i  (clk),
        .rst_ni (reset),
        .pin_i  (mosi),
        .level_o(mosi_lvl),
        .rise_o (unused_mosi_rise),
        .fall_o (unused_mosi_fall)
    );

    logic sample_ev, shift_ev;

    assign sample_ev = (SEDGE == EDGE_RISE) ? sclk_rise : sclk_fall;
    assign shift_ev  = (SEDGE == EDGE_RISE) ? sclk_fall : sclk_rise;

    spi_state_e        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [FB-1:0]     rx_q, rx_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              vld_q, vld_d;
    logic              err_q, err_d;
    logic              pend_q, pend_d;
    logic              tx_load, tx_shift;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rx_q    <= '0;
            data_q  <= '0;
            vld_q   <= 1'b0;
            err_q   <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rx_q    <= rx_d;
            data_q  <= data_d;
            vld_q   <= vld_d;
            err_q   <= err_d;
            pend_q  <= pend_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rx_d     = rx_q;
        data_d   = data_q;
        vld_d    = 1'b0;
        err_d    = 1'b0;
        pend_d   = 1'b0;
        tx_load  = 1'b0;
        tx_shift = 1'b0;
        unique case (state_q)
            IDLE: begin
                // A fall seen during CHECK is replayed here.
                if (ss_fall || (pend_q && !ss_lvl)) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    rx_d    = '0;
                    tx_load = 1'b1;
                end
            end
            SHIFT: begin
                if (ss_rise) begin
                    state_d = CHECK;
                end else begin
                    if (sample_ev) begin
                        rx_d = {rx_q[FB-2:0], mosi_lvl};
                        if (cnt_q != CNT_MAX) begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                    if (shift_ev && !(!CPHA && cnt_q == '0)) begin
                        tx_shift = 1'b1;
                    end
                end
            end
            CHECK: begin
                state_d = IDLE;
                pend_d  = ss_fall;
                if (cnt_q == CNT_FULL && (rx_q & PAD_MASK) == '0) begin
                    data_d = rx_q[DATA_W-1:0];
                    vld_d  = 1'b1;
                end else begin
                    err_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign o_data       = data_q;
    assign o_data_valid = vld_q;
    assign o_frame_err  = err_q;

`ifdef SPI_FRAME_TX_EN
    logic [FB-1:0] tx_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_q <= '0;
        end else if (tx_load) begin
            tx_q <= FB'(i_tx_data);
        end else if (tx_shift) begin
            tx_q <= {tx_q[FB-2:0], 1'b0};
        end
    end

    assign miso = (state_q == SHIFT) ? tx_q[FB-1] : 1'b0;
`else
    logic unused_tx;

    assign unused_tx = ^{i_tx_data, tx_load, tx_shift};
    assign miso      = 1'b0;
`endif

endmodule

// File: tb/tb_spi_frame_slave.sv
// Directed bench for spi_frame_slave: table of frames plus corner sequences.
module tb_spi_frame_slave;

    localparam int H = 500;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  sclk;
    logic        mosi = 1'b0;
    logic        ss = 1'b1;
    logic [13:0] tx_data = 14'h2A5A;
    logic [3:0]  miso, vld, err;
    logic [13:0] dat [4];

    int n_chk = 0;
    int n_err = 0;
    int vc [4];
    int ec [4];
    logic [15:0] rxcap;

    always #5 clk = ~clk;

    spi_frame_slave #(.DATA_W(14), .CPOL(1'b0), .CPHA(1'b0)) u_m0 (
        .clk(clk), .reset(reset), .sclk(sclk[0]), .mosi(mosi), .ss(ss),
        .miso(miso[0]), .i_tx_data(tx_data), .o_data(dat[0]),
        .o_data_valid(vld[0]), .o_frame_err(err[0]));

    spi_frame_slave #(.DATA_W(14), .CPOL(1'b0), .CPHA(1'b1)) u_m1 (
        .clk(clk), .reset(reset), .sclk(sclk[1]), .mosi(mosi), .ss(ss),
        .miso(miso[1]), .i_tx_data(tx_data), .o_data(dat[1]),
        .o_data_valid(vld[1]), .o_frame_err(err[1]));

    spi_frame_slave #(.DATA_W(14), .CPOL(1'b1), .CPHA(1'b0)) u_m2 (
        .clk(clk), .reset(reset), .sclk(sclk[2]), .mosi(mosi), .ss(ss),
        .miso(miso[2]), .i_tx_data(tx_data), .o_data(dat[2]),
        .o_data_valid(vld[2]), .o_frame_err(err[2]));

    spi_frame_slave #(.DATA_W(14), .CPOL(1'b1), .CPHA(1'b1)) u_m3 (
        .clk(clk), .reset(reset), .sclk(sclk[3]), .mosi(mosi), .ss(ss),
        .miso(miso[3]), .i_tx_data(tx_data), .o_data(dat[3]),
        .o_data_valid(vld[3]), .o_frame_err(err[3]));

    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (vld[k]) vc[k]++;
            if (err[k]) ec[k]++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send(input int m, input logic [15:0] fr,
                        input int nb, input bit raise);
        bit cpol;
        bit cpha;
        logic [31:0] w;
        cpol = (m >= 2);
        cpha = (m % 2 == 1);
        w = {fr, 16'h0000};
        rxcap = '0;
        ss = 1'b0;
        for (int i = 0; i < nb; i++) begin
            if (!cpha) mosi = w[31-i];
            #(H);
            sclk[m] = ~cpol;
            if (cpha) mosi = w[31-i];
            else rxcap = {rxcap[14:0], miso[m]};
            #(H);
            sclk[m] = cpol;
            if (cpha) rxcap = {rxcap[14:0], miso[m]};
        end
        #(H);
        if (raise) begin
            ss = 1'b1;
            #2000;
        end
    endtask

    typedef struct {
        logic [15:0] frame;
        int          nbits;
        logic [13:0] exp_data;
        int          exp_vld;
        int          exp_err;
    } vec_t;

    vec_t vecs [8];

    initial begin
        #20ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int v0;
        int e0;
        sclk = 4'b1100;
        vecs[0] = '{16'h0001, 16, 14'd1,     1, 0};
        vecs[1] = '{16'h00FF, 16, 14'd255,   1, 0};
        vecs[2] = '{16'h3FFF, 16, 14'd16383, 1, 0};
        vecs[3] = '{16'h04D2, 16, 14'd1234,  1, 0};
        vecs[4] = '{16'h04D2, 15, 14'd1234,  0, 1};
        vecs[5] = '{16'h04D2, 17, 14'd1234,  0, 1};
        vecs[6] = '{16'h4000, 16, 14'd1234,  0, 1};
        vecs[7] = '{16'h0000, 0,  14'd1234,  0, 1};

        #20;
        chk("rst_data", 32'(dat[0]), 32'd0);
        chk("rst_valid", 32'(vld[0]), 32'd0);
        chk("rst_err", 32'(err[0]), 32'd0);
        chk("rst_miso", 32'(miso[0]), 32'd0);
        reset = 1'b1;
        #200;

        for (int i = 0; i < 8; i++) begin
            v0 = vc[0];
            e0 = ec[0];
            send(0, vecs[i].frame, vecs[i].nbits, 1'b1);
            chk($sformatf("v%0d_data", i), 32'(dat[0]),
                32'(vecs[i].exp_data));
            chk($sformatf("v%0d_valid", i), 32'(vc[0] - v0),
                32'(vecs[i].exp_vld));
            chk($sformatf("v%0d_err", i), 32'(ec[0] - e0),
                32'(vecs[i].exp_err));
        end

        // Pulse lands on the 4th clk edge after SS rises and lasts one cycle.
        send(0, 16'h0155, 16, 1'b0);
        @(posedge clk);
        #1 ss = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk("lat_e3", 32'(vld[0]), 32'd0);
        @(posedge clk);
        #1 chk("lat_e4", 32'(vld[0]), 32'd1);
        chk("lat_data", 32'(dat[0]), 32'h155);
        @(posedge clk);
        #1 chk("lat_e5", 32'(vld[0]), 32'd0);
        #2000;

        for (int m = 1; m < 4; m++) begin
            v0 = vc[m];
            e0 = ec[m];
            send(m, 16'h04D2, 16, 1'b1);
            chk($sformatf("mode%0d_data", m), 32'(dat[m]), 32'd1234);
            chk($sformatf("mode%0d_valid", m), 32'(vc[m] - v0), 32'd1);
            chk($sformatf("mode%0d_err", m), 32'(ec[m] - e0), 32'd0);
        end

        send(0, 16'h0007, 16, 1'b1);
        chk("tx_rxdata", 32'(dat[0]), 32'd7);
`ifdef SPI_FRAME_TX_EN
        chk("tx_miso", 32'(rxcap), 32'h2A5A);
`else
        chk("tx_miso", 32'(rxcap), 32'h0000);
`endif

        v0 = vc[0];
        e0 = ec[0];
        send(0, 16'h04D2, 9, 1'b0);
        reset = 1'b0;
        #100;
        chk("abort_data", 32'(dat[0]), 32'd0);
        chk("abort_valid_lvl", 32'(vld[0]), 32'd0);
        reset = 1'b1;
        #200;
        ss = 1'b1;
        #2000;
        chk("abort_valid", 32'(vc[0] - v0), 32'd0);
        chk("abort_err", 32'(ec[0] - e0), 32'd0);
        send(0, 16'h0005, 16, 1'b1);
        chk("post_data", 32'(dat[0]), 32'd5);
        chk("post_valid", 32'(vc[0] - v0), 32'd1);
        chk("post_err", 32'(ec[0] - e0), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/spi_frame_slave.md
# spi_frame_slave

Parametrised SPI slave receiver that assembles one multi-byte frame per slave-select window into a DATA_W-bit word, MSB first, with zero-padded upper bits. It is the next-generation replacement for the fixed 14-bit, two-byte, mode-0 receiver in the slave design. It adds the following over that receiver:
- Configurable width and SPI mode.
- Frame-length and padding error detection.
- An optional full-duplex MISO return path.

It sits between the SPI pins (after the board pads) and the display/counter logic in the slave top level.

## Interface
- DATA_W, 14: payload width in bits, 1..32; frame length FRAME_BITS = 8*ceil(DATA_W/8).
- CPOL, 0: SCLK idle level.
- CPHA, 0: 0 = sample on the first SCLK edge; 1 = sample on the second SCLK edge.

- clk  input  1  system clock; must be at least 8x the SCLK frequency.
- reset  input  1  asynchronous, active-low reset.
- sclk  input  1  SPI clock, asynchronous to clk.
- mosi  input  1  SPI data in, asynchronous to clk.
- ss  input  1  slave select, active-low, asynchronous to clk.
- miso  output  1  SPI data out.
- i_tx_data  input  DATA_W  word returned on MISO; sampled when SS falls.
- o_data  output  DATA_W  last good frame payload.
- o_data_valid  output  1  one-cycle pulse when o_data updates.
- o_frame_err  output  1  one-cycle pulse for a bad frame.

## Operation
- **Input synchronisation:** sclk, mosi and ss each pass through a 2-flop synchroniser, followed by one history flop used for edge detection.
- **Edge definitions:**
  - Sample edge is the SCLK rising edge when CPOL==CPHA, and the falling edge otherwise.
  - Shift edge is the opposite SCLK edge.
- **State machine:** IDLE, SHIFT, CHECK.
  - IDLE → SHIFT on the synchronised SS falling edge. On this transition:
    - bit_cnt clears.
    - rx shift register clears.
    - tx shift register loads {pad zeros, i_tx_data}.
  - SHIFT, on each sample edge: rx shifts left with mosi in at the LSB; bit_cnt increments, saturating at FRAME_BITS+1.
  - SHIFT, on each shift edge: tx shifts left. With CPHA=0, a shift edge that precedes the first sample edge is ignored.
  - SHIFT → CHECK on the synchronised SS rising edge.
  - CHECK → IDLE unconditionally after one cycle. In CHECK:
    - Good frame (bit_cnt==FRAME_BITS and padding bits rx[FRAME_BITS-1:DATA_W] all zero): o_data <= rx[DATA_W-1:0] and o_data_valid pulses.
    - Any other frame: o_frame_err pulses and o_data holds its value. This covers short frames, long frames (saturated counter) and nonzero padding.
- **SCLK activity in IDLE** is ignored.
- **MISO** drives tx[FRAME_BITS-1] while in SHIFT and is 0 otherwise. Without the TX macro it is always 0.

## Timing
- **Reset values:** o_data=0, o_data_valid=0, o_frame_err=0, miso=0, state=IDLE, all shift registers and counters 0. Reset acts immediately (asynchronous) and may occur mid-frame. A frame in progress is discarded with no pulse, and the block waits for the next SS falling edge. If SS is already low when reset releases, no frame starts until SS goes high and then low again.
- **Latency:** o_data_valid / o_frame_err rise on the 4th clk rising edge after the SS pin rises (2 synchroniser edges, 1 edge-detect edge, 1 CHECK edge), and last exactly one cycle.
- **o_data** changes on the same edge as o_data_valid.
- **MISO** updates 3 clk cycles after the SCLK shift-edge pin transition.
- **Simultaneous events:**
  - An SS rising edge that coincides with a sample edge takes SS priority; that bit is not counted.
  - An SS rising edge followed by an SS falling edge within 2 cycles: the CHECK result is still reported and the new frame starts from IDLE on the following edge.
- **Zero-length frame** (SS low then high with no SCLK): o_frame_err pulses.

## Configuration
- **SPI_FRAME_TX_EN**
  - Defined: the tx shift register and MISO path are built, and i_tx_data is used.
  - Undefined: no tx register, miso is tied 0, and i_tx_data is unused. Receive behaviour is identical in both cases.

## Structure
- **Package spi_frame_pkg** holds:
  - the state enum type spi_state_e {IDLE, SHIFT, CHECK};
  - the function frame_bits(DATA_W);
  - the localparams SYNC_STAGES=2 and the sample-edge select.
- **Sub-module spi_pin_sync:** synchroniser plus edge detector, instantiated for sclk, ss and mosi. It outputs a level, a rise pulse and a fall pulse.

## Test plan
- DATA_W=14, mode 0, SCLK at 1 MHz, clk at 100 MHz. Frames 0x00,0x01 → 1; 0x00,0xFF → 255; 0x04,0xD2 → 1234; 0x3F,0xFF → 16383. Each frame gives one o_data_valid pulse and o_frame_err stays 0.
- Send 15 bits of 0x04D2, then raise SS → o_frame_err pulses once and o_data keeps 1234. Send 17 bits → o_frame_err pulses.
- Padding violation 0x40,0x00 → o_frame_err pulses and o_data is unchanged.
- Repeat 0x04,0xD2 for each CPOL/CPHA combination (modes 1–3) → o_data=1234 in every mode.
- SPI_FRAME_TX_EN defined, i_tx_data=0x2A5A → MISO bits captured on the master's sample edges read 0x2A,0x5A.
- Drive reset low after 9 bits of a frame, release it, then send a full frame of 0x00,0x05 → no pulse for the aborted frame, then o_data=5 with one valid pulse.
